// File: rtl/vga_text_renderer.sv
// 640x480@60 text-mode pixel engine: 80x30 cells, 8x16 glyphs, 3-stage fetch/render pipeline at Clk/2.
// Optional blinking cursor cell is compiled in with `define VGA_TEXT_CURSOR_EN.
module vga_text_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COLS     = 80
) (
  input  logic        Clk,
  input  logic        Reset_h,
`ifdef VGA_TEXT_CURSOR_EN
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
`endif
  output logic [11:0] vram_addr,
  input  logic [7:0]  vram_rdata,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [11:0] fg_color,
  input  logic [11:0] bg_color,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hs,
  output logic        vs,
  output logic        frame_tick
);

  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] COLS_W    = 12'(COLS);

  // phase_q=0 marks a pixel tick, so the first Clk after reset release advances the raster
  logic        phase_q, phase_d;
  logic        pix_en;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        frame_tick_q, frame_tick_d;

  // S1
  logic [11:0] vram_addr_q, vram_addr_d;
  logic [2:0]  col1_q, col1_d;
  logic [3:0]  row1_q, row1_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d, blank1_q, blank1_d, cur1_q, cur1_d;
  // S2
  logic [10:0] font_addr_q, font_addr_d;
  logic [2:0]  col2_q, col2_d;
  logic        inv2_q, inv2_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d, blank2_q, blank2_d;
  // S3
  logic [11:0] rgb_q, rgb_d;
  logic        hs3_q, hs3_d, vs3_q, vs3_d;

  logic        h_wrap, v_wrap;
  logic        hs_raw, vs_raw, blank_raw;
  logic [11:0] row_idx, col_idx, cell_addr;
  logic        cursor_hit;
  logic        pix_bit;

  assign pix_en    = ~phase_q;
  assign h_wrap    = (h_cnt_q == H_LAST);
  assign v_wrap    = (v_cnt_q == V_LAST);
  assign hs_raw    = ~((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
  assign vs_raw    = ~((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
  assign blank_raw = (h_cnt_q >= H_VIS) || (v_cnt_q >= V_VIS);
  assign row_idx   = 12'(v_cnt_q >> 4);
  assign col_idx   = 12'(h_cnt_q >> 3);
  assign cell_addr = 12'(row_idx * COLS_W) + col_idx;

`ifdef VGA_TEXT_CURSOR_EN
  logic [4:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_tick_q ? frame_cnt_q + 5'd1 : frame_cnt_q;
  assign cursor_hit  = frame_cnt_q[4] && (col_idx[6:0] == cursor_col) &&
                       (row_idx[4:0] == cursor_row);

  always_ff @(posedge Clk) begin
    if (Reset_h) frame_cnt_q <= 5'd0;
    else         frame_cnt_q <= frame_cnt_d;
  end
`else
  assign cursor_hit = 1'b0;
`endif

  always_comb begin
    phase_d      = ~phase_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    frame_tick_d = pix_en && h_wrap && v_wrap;
    if (pix_en) begin
      if (h_wrap) begin
        h_cnt_d = 10'd0;
        v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_comb begin
    vram_addr_d = vram_addr_q;
    col1_d      = col1_q;
    row1_d      = row1_q;
    hs1_d       = hs1_q;
    vs1_d       = vs1_q;
    blank1_d    = blank1_q;
    cur1_d      = cur1_q;
    if (pix_en) begin
      col1_d   = h_cnt_q[2:0];
      row1_d   = v_cnt_q[3:0];
      hs1_d    = hs_raw;
      vs1_d    = vs_raw;
      blank1_d = blank_raw;
      cur1_d   = cursor_hit && !blank_raw;
      // Below the active area the address parks at 0; in line blanking it holds, so no index ever exceeds the buffer
      if (!blank_raw)              vram_addr_d = cell_addr;
      else if (v_cnt_q >= V_VIS)   vram_addr_d = 12'd0;
    end
  end

  always_comb begin
    font_addr_d = font_addr_q;
    col2_d      = col2_q;
    inv2_d      = inv2_q;
    hs2_d       = hs2_q;
    vs2_d       = vs2_q;
    blank2_d    = blank2_q;
    if (pix_en) begin
      font_addr_d = {vram_rdata[6:0], row1_q};
      inv2_d      = vram_rdata[7] ^ cur1_q;
      col2_d      = col1_q;
      hs2_d       = hs1_q;
      vs2_d       = vs1_q;
      blank2_d    = blank1_q;
    end
  end

  always_comb begin
    pix_bit = font_data[3'd7 - col2_q] ^ inv2_q;
    rgb_d   = rgb_q;
    hs3_d   = hs3_q;
    vs3_d   = vs3_q;
    if (pix_en) begin
      rgb_d = blank2_q ? 12'h000 : (pix_bit ? fg_color : bg_color);
      hs3_d = hs2_q;
      vs3_d = vs2_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      phase_q      <= 1'b0;
      h_cnt_q      <= 10'd0;
      v_cnt_q      <= 10'd0;
      frame_tick_q <= 1'b0;
      vram_addr_q  <= 12'd0;
      col1_q       <= 3'd0;
      row1_q       <= 4'd0;
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      blank1_q     <= 1'b1;
      cur1_q       <= 1'b0;
      font_addr_q  <= 11'd0;
      col2_q       <= 3'd0;
      inv2_q       <= 1'b0;
      hs2_q        <= 1'b1;
      vs2_q        <= 1'b1;
      blank2_q     <= 1'b1;
      rgb_q        <= 12'h000;
      hs3_q        <= 1'b1;
      vs3_q        <= 1'b1;
    end else begin
      phase_q      <= phase_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      frame_tick_q <= frame_tick_d;
      vram_addr_q  <= vram_addr_d;
      col1_q       <= col1_d;
      row1_q       <= row1_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      blank1_q     <= blank1_d;
      cur1_q       <= cur1_d;
      font_addr_q  <= font_addr_d;
      col2_q       <= col2_d;
      inv2_q       <= inv2_d;
      hs2_q        <= hs2_d;
      vs2_q        <= vs2_d;
      blank2_q     <= blank2_d;
      rgb_q        <= rgb_d;
      hs3_q        <= hs3_d;
      vs3_q        <= vs3_d;
    end
  end

  assign vram_addr  = vram_addr_q;
  assign font_addr  = font_addr_q;
  assign red        = rgb_q[11:8];
  assign green      = rgb_q[7:4];
  assign blue       = rgb_q[3:0];
  assign hs         = hs3_q;
  assign vs         = vs3_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer; vertical timing shortened (32 active + 4 lines) to keep a frame short.
module tb_vga_text_renderer;

  logic        Clk = 1'b0;
  logic        Reset_h = 1'b1;
  logic [11:0] vram_addr;
  logic [7:0]  vram_rdata = 8'h00;
  logic [10:0] font_addr;
  logic [7:0]  font_data = 8'h00;
  logic [11:0] fg_color = 12'h000;
  logic [11:0] bg_color = 12'h000;
  logic [3:0]  red, green, blue;
  logic        hs, vs, frame_tick;

  logic [7:0]  vram [4096];
  logic [7:0]  font [2048];
  int          cyc = 0;
  int          ft_count = 0;
  int          total = 0;
  int          bad = 0;

  vga_text_renderer #(
    .V_ACTIVE(32), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .Clk(Clk), .Reset_h(Reset_h),
    .vram_addr(vram_addr), .vram_rdata(vram_rdata),
    .font_addr(font_addr), .font_data(font_data),
    .fg_color(fg_color), .bg_color(bg_color),
    .red(red), .green(green), .blue(blue),
    .hs(hs), .vs(vs), .frame_tick(frame_tick)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk) begin
    vram_rdata <= vram[vram_addr];
    font_data  <= font[font_addr];
  end

  // cyc = number of rising edges since reset release
  always @(posedge Clk) cyc <= Reset_h ? 0 : cyc + 1;

  always @(negedge Clk) if (frame_tick === 1'b1) ft_count <= ft_count + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return hs;
      1:       return vs;
      default: return frame_tick;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic lvl, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (sig(which) === lvl) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset_h = 1'b1;
    repeat (2) @(negedge Clk);
    Reset_h = 1'b0;
  endtask

  // pixel for raster index n = v*800+h is visible at cyc 2n+5
  task automatic chk_pix(input string tag, input int n, input logic [11:0] exp);
    wait_cyc(2 * n + 5);
    chk(tag, {20'd0, red, green, blue}, {20'd0, exp});
  endtask

  initial begin
    int t_fall, t_rise, t_fall2, t_vs_fall, t_vs_rise, t_ft, ft_base;
    logic [11:0] p;
    logic [7:0]  glyph;

    for (int i = 0; i < 4096; i++) vram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) font[i] = 8'h00;
    vram[0] = 8'h41;
    font[11'h410] = 8'h18;
    glyph = 8'h18;
    fg_color = 12'hFFF;
    bg_color = 12'h00F;

    // glyph row 0 of 'A' on line 0
    do_reset();
    chk("rst_rgb", {20'd0, red, green, blue}, 32'h0);
    chk("rst_hs", {31'd0, hs}, 32'd1);
    chk("rst_vs", {31'd0, vs}, 32'd1);
    chk("rst_vram_addr", {20'd0, vram_addr}, 32'd0);
    chk("rst_font_addr", {21'd0, font_addr}, 32'd0);
    chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    for (int c = 0; c < 8; c++) begin
      p = glyph[7 - c] ? 12'hFFF : 12'h00F;
      chk($sformatf("glyph_px%0d", c), 2 * c + 5 == 0 ? 32'hDEAD : 32'h0, 32'h0);
      chk_pix($sformatf("glyph_rgb%0d", c), c, p);
    end
    bg_color = 12'h0F0;
    chk_pix("bg_change_px8", 8, 12'h0F0);
    bg_color = 12'h00F;

    // bit7 set inverts the cell
    vram[0] = 8'hC1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      p = glyph[7 - c] ? 12'h00F : 12'hFFF;
      chk_pix($sformatf("inv_rgb%0d", c), c, p);
    end

    // full frame: sync timing, blanking, address generation
    fg_color = 12'hFFF;
    bg_color = 12'hFFF;
    ft_base = ft_count;
    do_reset();
    wait_for(0, 1'b0, 3000, t_fall);
    chk("hs_first_fall", t_fall, 32'd1317);
    wait_for(0, 1'b1, 3000, t_rise);
    chk("hs_low_clk", t_rise - t_fall, 32'd192);
    wait_for(0, 1'b0, 3000, t_fall2);
    chk("hs_period_clk", t_fall2 - t_fall, 32'd1600);
    chk_pix("blank_h639_active", 2 * 800 + 639, 12'hFFF);
    chk_pix("blank_h640", 2 * 800 + 640, 12'h000);
    chk_pix("blank_h700", 2 * 800 + 700, 12'h000);
    chk_pix("blank_h799", 2 * 800 + 799, 12'h000);
    chk_pix("blank_next_h0", 3 * 800, 12'hFFF);
    wait_cyc(2 * (5 * 800 + 700) + 1);
    chk("addr_hblank_hold", {20'd0, vram_addr}, 32'd79);
    wait_cyc(2 * (16 * 800 + 40) + 1);
    chk("addr_h40_v16", {20'd0, vram_addr}, 32'd85);
    wait_cyc(2 * (31 * 800 + 639) + 1);
    chk("addr_last_cell", {20'd0, vram_addr}, 32'd159);
    wait_for(1, 1'b0, 5000, t_vs_fall);
    chk("vs_fall", t_vs_fall, 32'd52805);
    wait_cyc(2 * (33 * 800 + 100) + 1);
    chk("addr_vblank_zero", {20'd0, vram_addr}, 32'd0);
    wait_for(1, 1'b1, 5000, t_vs_rise);
    chk("vs_low_clk", t_vs_rise - t_vs_fall, 32'd3200);
    chk("ft_none_early", ft_count - ft_base, 32'd0);
    wait_for(2, 1'b1, 5000, t_ft);
    chk("frame_tick_at", t_ft, 32'd57599);
    @(negedge Clk);
    chk("frame_tick_single", {31'd0, frame_tick}, 32'd0);
    chk("frame_tick_count", ft_count - ft_base, 32'd1);

    // one-Clk reset mid-line at (300,2)
    do_reset();
    wait_cyc(2 * (2 * 800 + 300) - 1);
    chk("pre_reset_rgb", {20'd0, red, green, blue}, 32'hFFF);
    Reset_h = 1'b1;
    @(negedge Clk);
    Reset_h = 1'b0;
    chk("mid_rst_rgb", {20'd0, red, green, blue}, 32'h0);
    chk("mid_rst_hs", {31'd0, hs}, 32'd1);
    chk("mid_rst_vs", {31'd0, vs}, 32'd1);
    chk("mid_rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    chk("mid_rst_vram_addr", {20'd0, vram_addr}, 32'd0);
    wait_for(0, 1'b0, 3000, t_fall);
    chk("restart_hs_fall", t_fall, 32'd1317);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
